// File: rtl/gpc_pkg.sv
// Shared GPC front-end definitions: datapath defaults, the fetch FSM states and
// the instruction-memory transaction shapes (also used by the LSU).
package gpc_pkg;

   localparam int          GPC_XLEN        = 32;
   localparam logic [31:0] GPC_RESET_PC    = 32'h8000_0000;
   localparam logic [31:0] GPC_EBREAK_INST = 32'h0010_0073;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [GPC_XLEN-1:0] addr;
   } imem_req_t;

   typedef struct packed {
      logic [31:0] data;
   } imem_rsp_t;

endpackage

// File: rtl/gpc_ifu.sv
// GPC instruction-fetch unit: one outstanding imem request, one-entry output
// register towards decode, redirect handling with response kill, sticky EBREAK halt.
module gpc_ifu
   import gpc_pkg::*;
#(
   parameter int               XLEN        = GPC_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(GPC_RESET_PC),
   parameter logic [31:0]      EBREAK_INST = GPC_EBREAK_INST
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [31:0]      out_inst,
   output logic [XLEN-1:0]  pc,
   output logic             ebreak
);

   ifu_state_e       state, state_nxt;
   logic             kill, kill_nxt;
   logic [XLEN-1:0]  pc_nxt, target;
   logic             ov_nxt, eb_nxt;
   logic [XLEN-1:0]  opc_nxt;
   logic [31:0]      oinst_nxt;
   logic             req_fire;

   // Only issue when the output slot is guaranteed free by the time data returns.
   assign imem_req_valid = !rst && (state == REQ) && (!out_valid || out_ready);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign target         = redirect_pc & ~XLEN'(3);

   always_comb begin
      state_nxt = state;
      kill_nxt  = kill;
      pc_nxt    = pc;
      ov_nxt    = out_valid && !out_ready;
      opc_nxt   = out_pc;
      oinst_nxt = out_inst;
      eb_nxt    = ebreak;
      case (state)
         REQ: begin
            if (req_fire) begin
               state_nxt = WAIT;
               kill_nxt  = redirect_valid;
            end
            if (redirect_valid) begin
               pc_nxt = target;
               ov_nxt = 1'b0;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_nxt = target;
               ov_nxt = 1'b0;
            end
            if (imem_rsp_valid) begin
               state_nxt = REQ;
               kill_nxt  = 1'b0;
               if (!redirect_valid && !kill) begin
                  ov_nxt    = 1'b1;
                  opc_nxt   = pc;
                  oinst_nxt = imem_rsp_data;
                  pc_nxt    = pc + XLEN'(4);
                  if (imem_rsp_data == EBREAK_INST) begin
                     eb_nxt    = 1'b1;
                     state_nxt = HALT;
                  end
               end
            end else if (redirect_valid) begin
               // The in-flight response belongs to the old path; drop it on arrival.
               kill_nxt = 1'b1;
            end
         end
         HALT: ;
         default: state_nxt = REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= REQ;
         kill      <= 1'b0;
         pc        <= RESET_PC;
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_inst  <= '0;
         ebreak    <= 1'b0;
      end else begin
         state     <= state_nxt;
         kill      <= kill_nxt;
         pc        <= pc_nxt;
         out_valid <= ov_nxt;
         out_pc    <= opc_nxt;
         out_inst  <= oinst_nxt;
         ebreak    <= eb_nxt;
      end
   end

endmodule

// File: tb/tb_gpc_ifu.sv
// Directed bench for gpc_ifu: stimulus pushes expected deliveries into a
// scoreboard, a negedge monitor checks every instruction decode accepts.
module tb_gpc_ifu;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_inst, pc;
   logic        ebreak;

   localparam logic [31:0] EBRK = 32'h0010_0073;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   exp_t sb[$];

   gpc_ifu dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst),
      .pc(pc), .ebreak(ebreak)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a request, checks its address and lets the handshake edge pass.
   task automatic wait_req(input string name, input logic [31:0] exp_addr, output int waited);
      bit seen = 0;
      waited = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (imem_req_valid) seen = 1;
         else waited++;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no request expected addr %h", name, exp_addr);
      end else begin
         chk(name, imem_req_addr, exp_addr);
      end
      tick();
   endtask

   task automatic respond(input logic [31:0] data, input int gap, input bit push, input logic [31:0] epc);
      exp_t e;
      repeat (gap - 1) tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      if (push) begin
         e.pc   = epc;
         e.inst = data;
         sb.push_back(e);
      end
      tick();
      imem_rsp_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got pc %h inst %h expected nothing", out_pc, out_inst);
         end else begin
            e = sb.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_inst", out_inst, e.inst);
         end
      end
   end

   initial begin
      int w;
      rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

      // Reset state
      tick(); tick();
      @(negedge clk);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_ebreak", {31'b0, ebreak}, 32'd0);
      chk("rst_pc", pc, 32'h8000_0000);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: first fetch and delivery
      wait_req("req0", 32'h8000_0000, w);
      respond(32'h0000_0013, 1, 1, 32'h8000_0000);
      chk("t1_pc", pc, 32'h8000_0004);

      // 2: decode back-pressure blocks new requests and holds the output
      out_ready = 1'b0;
      @(negedge clk);
      chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
      chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
      tick(); tick();
      @(negedge clk);
      chk("t2_req_blocked2", {31'b0, imem_req_valid}, 32'd0);
      chk("t2_pc_hold", out_pc, 32'h8000_0000);
      chk("t2_inst_hold", out_inst, 32'h0000_0013);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_req("req1", 32'h8000_0004, w);
      chk("t2_same_cycle", w, 0);
      respond(32'h0000_0093, 1, 1, 32'h8000_0004);

      // 3: redirect while waiting, stale response dropped
      wait_req("req2", 32'h8000_0008, w);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      tick();
      respond(32'h0000_0013, 1, 0, 32'h0);
      chk("t3_out_valid", {31'b0, out_valid}, 32'd0);
      chk("t3_pc", pc, 32'h8000_0100);
      wait_req("req3", 32'h8000_0100, w);
      respond(32'h0000_0013, 1, 1, 32'h8000_0100);

      // 6: redirect in REQ without handshake, then PC wrap
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      chk("t6_pc_target", pc, 32'hFFFF_FFFC);
      wait_req("req4", 32'hFFFF_FFFC, w);
      respond(32'h0000_0013, 1, 1, 32'hFFFF_FFFC);
      chk("t6_pc_wrap", pc, 32'h0000_0000);

      // 4: EBREAK halts permanently, redirect ignored
      wait_req("req5", 32'h0000_0000, w);
      respond(EBRK, 2, 1, 32'h0000_0000);
      chk("t4_ebreak", {31'b0, ebreak}, 32'd1);
      chk("t4_out_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_pc", pc, 32'h0000_0004);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
         @(posedge clk); #1;
      end
      redirect_valid = 1'b0;
      chk("t4_pc_ignored", pc, 32'h0000_0004);
      chk("t4_ebreak_sticky", {31'b0, ebreak}, 32'd1);

      // 5: reset clears halt; reset during WAIT ignores the late response
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_ebreak_clr", {31'b0, ebreak}, 32'd0);
      chk("t5_pc", pc, 32'h8000_0000);
      wait_req("req6", 32'h8000_0000, w);
      rst = 1'b1;
      tick();
      rst = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = EBRK;
      @(negedge clk);
      chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t5_req_addr", imem_req_addr, 32'h8000_0000);
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
      chk("t5_ebreak", {31'b0, ebreak}, 32'd0);
      chk("t5_pc_hold", pc, 32'h8000_0000);
      imem_req_ready = 1'b1;
      wait_req("req7", 32'h8000_0000, w);
      respond(32'h0000_0013, 3, 1, 32'h8000_0000);

      repeat (3) tick();
      chk("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpc_ifu.md
Name: gpc_ifu

Overview:
gpc_ifu is the parametrised instruction-fetch unit of the Gwen Processor Core (GPC), replacing the fixed-PC / constant-ebreak front end. It holds the architectural fetch PC from a configurable reset vector and issues one instruction-memory request at a time over a valid/ready handshake. It delivers fetched instructions to decode through a one-entry output register, accepts branch/jump redirects from execute, and halts permanently on EBREAK.

Parameters:
XLEN, 32, width of PC and memory address
RESET_PC, 32'h8000_0000, PC loaded on reset
EBREAK_INST, 32'h0010_0073, encoding that triggers halt

Ports:
clk  input  1  core clock; all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address, equals pc
imem_rsp_valid  input  1  response data valid (cannot be back-pressured)
imem_rsp_data  input  32  fetched instruction
redirect_valid  input  1  execute requests PC change
redirect_pc  input  XLEN  redirect target
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts instruction
out_pc  output  XLEN  PC of delivered instruction
out_inst  output  32  delivered instruction
pc  output  XLEN  current fetch PC register
ebreak  output  1  sticky halt flag

Behaviour:
- Reset (rst=1 at an edge, any state):
  - pc=RESET_PC; state=REQ; kill=0.
  - out_valid=0, out_pc=0, out_inst=0, ebreak=0.
  - imem_req_valid is 0 during the reset cycle.
- States: REQ, WAIT, HALT. At most one request is outstanding.
- REQ:
  - imem_req_valid = !out_valid || out_ready, so an issued response always has a free slot.
  - On handshake (valid && ready): go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill=0: out_inst<=data, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - If data==EBREAK_INST: ebreak<=1 and go to HALT. Otherwise go to REQ.
- HALT:
  - No requests are issued; redirect is ignored.
  - out register drains normally.
  - Exit only via rst.
- Output register: out_valid clears on (out_valid && out_ready) unless refilled in the same cycle. Fields are held stable while out_valid && !out_ready.
- Redirect (highest priority, outside HALT):
  - Target is redirect_pc with bits[1:0] forced to 0.
  - out_valid<=0 in the same edge, flushing the held instruction.
  - In REQ without handshake: pc<=target.
  - In REQ with a simultaneous handshake: the request to the old address cannot be retracted. pc<=target, go to WAIT with kill=1.
  - In WAIT without rsp_valid: pc<=target, kill<=1. A later redirect overwrites pc.
  - In WAIT with rsp_valid, or with kill=1 when the response arrives: drop the response, clear kill, go to REQ with pc=target. Neither out nor ebreak is updated, even if the data was EBREAK.
- imem_rsp_valid outside WAIT is ignored. This covers stale responses after reset.
- Arithmetic: pc+4 wraps modulo 2^XLEN.
- Latency: request handshake at cycle N, response at cycle M>N, out_valid visible after edge M; best case one instruction per 2 cycles.

Decomposition:
- Package gpc_pkg holds:
  - XLEN default, RESET_PC default and the EBREAK_INST encoding constant;
  - the ifu_state_e enum (REQ, WAIT, HALT) and an imem request/response struct typedef for reuse by the LSU.
- No sub-module: the FSM, PC register and one-entry output register fit in one module of about 200 lines.

Test Plan:
1. Reset released, req_ready=1, rsp 0x0000_0013 one cycle later -> req_addr 0x8000_0000; out_valid=1 with out_pc 0x8000_0000, out_inst 0x13; next req_addr 0x8000_0004.
2. out_ready=0 while out_valid=1 -> imem_req_valid stays 0 and out fields stable; raise out_ready -> req issued in that same cycle.
3. Redirect to 0x8000_0102 while in WAIT, rsp arrives 2 cycles later -> response dropped, out_valid=0, next req_addr 0x8000_0100.
4. Response 0x0010_0073 -> delivered with out_valid=1; ebreak=1 after the same edge; imem_req_valid stays 0 indefinitely; redirect ignored; only rst clears ebreak.
5. rst pulsed in WAIT, rsp_valid arrives in the following cycle -> pc=0x8000_0000, out_valid=0, ebreak=0, response ignored, fresh req to 0x8000_0000.
6. Redirect to 0xFFFF_FFFC, response 0x13 -> out_pc 0xFFFF_FFFC; next req_addr 0x0000_0000 (wrap).
